// File: rtl/fetch_ctrl_defs.sv
// Shared definitions for the fetch-stage sequencing controller: opcodes,
// instruction field extraction, FSM state encoding and the control bundle.
package fetch_ctrl_defs;

   localparam logic [3:0] OPC_LOAD = 4'h8;
   localparam logic [3:0] OPC_JMP  = 4'hC;
   localparam logic [3:0] OPC_HALT = 4'hF;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH2   = 2'd2,
      HALT     = 2'd3
   } state_e;

   typedef struct packed {
      logic       stall;
      logic       stall_pm;
      logic       pc_mux_sel;
      logic [7:0] jmp_loc;
      logic       flush_ifid;
      logic       bubble_idex;
      logic       halted;
   } ctrl_t;

   // Field layout: op[23:20] rd[19:16] rs1[15:12] rs2[11:8] imm[7:0]
   function automatic logic [3:0] f_op(input logic [23:0] ins);
      return ins[23:20];
   endfunction

   function automatic logic [3:0] f_rd(input logic [23:0] ins);
      return ins[19:16];
   endfunction

   function automatic logic [3:0] f_rs1(input logic [23:0] ins);
      return ins[15:12];
   endfunction

   function automatic logic [3:0] f_rs2(input logic [23:0] ins);
      return ins[11:8];
   endfunction

   function automatic logic [7:0] f_imm(input logic [23:0] ins);
      return ins[7:0];
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in decode whose destination feeds a source
// operand of the instruction leaving fetch. Register 0 never hazards.
module hazard_detect
   import fetch_ctrl_defs::*;
#(
   parameter logic [3:0] OP_LOAD = OPC_LOAD
) (
   input  logic [23:0] ins_id,
   input  logic [23:0] ins_if,
   output logic        lu_hit
);

   logic [3:0] w_rd;
   logic       w_unused_bits;

   assign w_rd   = f_rd(ins_id);
   assign lu_hit = (f_op(ins_id) == OP_LOAD) && (w_rd != 4'd0) &&
                   ((w_rd == f_rs1(ins_if)) || (w_rd == f_rs2(ins_if)));

   assign w_unused_bits = ^{ins_id[15:0], ins_if[23:16], ins_if[7:0]};

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch sequencing controller: resolves load-use stalls, ID jumps, EX taken
// branches and HALT into Mealy PC-control outputs plus pipeline flush strobes.
module fetch_hazard_ctrl
   import fetch_ctrl_defs::*;
#(
   parameter int         LOAD_USE_CYCLES = 1,
   parameter logic [3:0] OP_LOAD         = OPC_LOAD,
   parameter logic [3:0] OP_JMP          = OPC_JMP,
   parameter logic [3:0] OP_HALT         = OPC_HALT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] ins_if,
   input  logic [23:0] ins_id,
   input  logic        ex_br_valid,
   input  logic        ex_br_taken,
   input  logic [7:0]  ex_br_target,
   input  logic        resume,
   output logic        Stall,
   output logic        Stall_pm,
   output logic        pc_mux_sel,
   output logic [7:0]  jmp_loc,
   output logic        flush_ifid,
   output logic        bubble_idex,
   output logic        halted
);

   localparam logic [1:0] LU_INIT = 2'(LOAD_USE_CYCLES - 1);

   state_e     r_state, w_next_state;
   logic [1:0] r_cnt, w_next_cnt;
   ctrl_t      w_ctrl, w_out;
   logic       w_lu_hit, w_br, w_unused_bits;
   logic [3:0] w_id_op;

   hazard_detect #(.OP_LOAD(OP_LOAD)) u_hazard_detect (
      .ins_id (ins_id),
      .ins_if (ins_if),
      .lu_hit (w_lu_hit)
   );

   assign w_br          = ex_br_valid & ex_br_taken;
   assign w_id_op       = f_op(ins_id);
   assign w_unused_bits = ^ins_id[15:8];

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_ctrl       = '0;
      case (r_state)
         RUN: begin
            if (w_br) begin
               w_ctrl.pc_mux_sel  = 1'b1;
               w_ctrl.jmp_loc     = ex_br_target;
               w_ctrl.flush_ifid  = 1'b1;
               w_ctrl.bubble_idex = 1'b1;
               w_next_state       = FLUSH2;
            end else if (w_id_op == OP_JMP) begin
               w_ctrl.pc_mux_sel  = 1'b1;
               w_ctrl.jmp_loc     = f_imm(ins_id);
               w_ctrl.flush_ifid  = 1'b1;
            end else if (w_id_op == OP_HALT) begin
               w_ctrl.stall       = 1'b1;
               w_ctrl.stall_pm    = 1'b1;
               w_ctrl.flush_ifid  = 1'b1;
               w_next_state       = HALT;
            end else if (w_lu_hit) begin
               w_ctrl.stall       = 1'b1;
               w_ctrl.stall_pm    = 1'b1;
               w_ctrl.bubble_idex = 1'b1;
               w_next_cnt         = LU_INIT;
               w_next_state       = (LOAD_USE_CYCLES == 1) ? RUN : LU_STALL;
            end
         end
         LU_STALL: begin
            if (w_br) begin
               w_ctrl.pc_mux_sel  = 1'b1;
               w_ctrl.jmp_loc     = ex_br_target;
               w_ctrl.flush_ifid  = 1'b1;
               w_ctrl.bubble_idex = 1'b1;
               w_next_cnt         = 2'd0;
               w_next_state       = FLUSH2;
            end else begin
               w_ctrl.stall       = 1'b1;
               w_ctrl.stall_pm    = 1'b1;
               w_ctrl.bubble_idex = 1'b1;
               w_next_cnt         = r_cnt - 2'd1;
               // Exit once the decremented count hits zero: LOAD_USE_CYCLES stalls in total.
               w_next_state       = (r_cnt <= 2'd1) ? RUN : LU_STALL;
            end
         end
         FLUSH2: begin
            w_ctrl.flush_ifid  = 1'b1;
            w_ctrl.bubble_idex = 1'b1;
            w_next_state       = RUN;
            if (w_br) begin
               w_ctrl.pc_mux_sel = 1'b1;
               w_ctrl.jmp_loc    = ex_br_target;
               w_next_state      = FLUSH2;
            end
         end
         HALT: begin
            w_ctrl.stall       = 1'b1;
            w_ctrl.stall_pm    = 1'b1;
            w_ctrl.halted      = 1'b1;
            w_ctrl.bubble_idex = 1'b1;
            if (resume) begin
               w_ctrl.flush_ifid = 1'b1;
               w_next_state      = RUN;
            end
         end
         default: w_next_state = RUN;
      endcase
   end

   // Outputs are combinational from inputs too, so reset must mask them directly.
   assign w_out       = reset ? '0 : w_ctrl;
   assign Stall       = w_out.stall;
   assign Stall_pm    = w_out.stall_pm;
   assign pc_mux_sel  = w_out.pc_mux_sel;
   assign jmp_loc     = w_out.jmp_loc;
   assign flush_ifid  = w_out.flush_ifid;
   assign bubble_idex = w_out.bubble_idex;
   assign halted      = w_out.halted;

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench for fetch_hazard_ctrl: two instances (LOAD_USE_CYCLES 1 and 3)
// share stimulus; the driver queues expectations, a negedge monitor checks them.
module tb_fetch_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] ins_if = '0, ins_id = '0;
   logic        ex_br_valid = 1'b0, ex_br_taken = 1'b0, resume = 1'b0;
   logic [7:0]  ex_br_target = '0;

   logic       s1, p1, m1, f1, b1, h1, s3, p3, m3, f3, b3, h3;
   logic [7:0] l1, l3;

   typedef struct {
      string       name;
      logic [13:0] e1;
      logic [13:0] e3;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   fetch_hazard_ctrl #(.LOAD_USE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .ins_if(ins_if), .ins_id(ins_id),
      .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
      .ex_br_target(ex_br_target), .resume(resume),
      .Stall(s1), .Stall_pm(p1), .pc_mux_sel(m1), .jmp_loc(l1),
      .flush_ifid(f1), .bubble_idex(b1), .halted(h1)
   );

   fetch_hazard_ctrl #(.LOAD_USE_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .ins_if(ins_if), .ins_id(ins_id),
      .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
      .ex_br_target(ex_br_target), .resume(resume),
      .Stall(s3), .Stall_pm(p3), .pc_mux_sel(m3), .jmp_loc(l3),
      .flush_ifid(f3), .bubble_idex(b3), .halted(h3)
   );

   // Vector layout: {Stall, Stall_pm, pc_mux_sel, jmp_loc[7:0], flush_ifid, bubble_idex, halted}
   function automatic logic [13:0] v(input bit s, input bit p, input bit m,
                                     input logic [7:0] l, input bit f,
                                     input bit b, input bit h);
      return {s, p, m, l, f, b, h};
   endfunction

   localparam logic [13:0] ZERO = 14'd0;
   localparam logic [13:0] LUS  = {3'b110, 8'h00, 3'b010};
   localparam logic [13:0] FL2  = {3'b000, 8'h00, 3'b110};
   localparam logic [13:0] HLT  = {3'b110, 8'h00, 3'b011};

   task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got S/Spm/sel/loc/fl/bub/h=%b/%b/%b/%h/%b/%b/%b expected %b/%b/%b/%h/%b/%b/%b",
                    nm, got[13], got[12], got[11], got[10:3], got[2], got[1], got[0],
                    exp[13], exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.name, "/lu1"}, {s1, p1, m1, l1, f1, b1, h1}, e.e1);
         check({e.name, "/lu3"}, {s3, p3, m3, l3, f3, b3, h3}, e.e3);
      end
   end

   task automatic step(input string nm, input logic [23:0] fi, input logic [23:0] di,
                       input logic bv, input logic bt, input logic [7:0] tg,
                       input logic rs, input logic rst,
                       input logic [13:0] x1, input logic [13:0] x3);
      exp_t e;
      @(posedge clk);
      #1;
      ins_if = fi; ins_id = di; ex_br_valid = bv; ex_br_taken = bt;
      ex_br_target = tg; resume = rs; reset = rst;
      e.name = nm; e.e1 = x1; e.e3 = x3;
      sb_q.push_back(e);
   endtask

   initial begin
      step("reset_init", 24'h0, 24'hC0005A, 0, 0, 8'h00, 0, 1, ZERO, ZERO);
      step("idle",       24'h0, 24'h0,     0, 0, 8'h00, 0, 0, ZERO, ZERO);

      // Load-use via rs1: one stall for LOAD_USE_CYCLES=1, three for 3
      step("lu_rs1",     24'h113000, 24'h830000, 0, 0, 8'h00, 0, 0, LUS,  LUS);
      step("lu_after1",  24'h113000, 24'h0,      0, 0, 8'h00, 0, 0, ZERO, LUS);
      step("lu_after2",  24'h0,      24'h0,      0, 0, 8'h00, 0, 0, ZERO, LUS);
      step("lu_done",    24'h0,      24'h0,      0, 0, 8'h00, 0, 0, ZERO, ZERO);
      step("lu_rd0",     24'h100000, 24'h800000, 0, 0, 8'h00, 0, 0, ZERO, ZERO);

      // Load-use via rs2, then a taken branch in the second stall cycle
      step("lu_rs2",     24'h100500, 24'h850000, 0, 0, 8'h00, 0, 0, LUS, LUS);
      step("br_in_lu",   24'h0, 24'h0, 1, 1, 8'hFF, 0, 0,
           v(0,0,1,8'hFF,1,1,0), v(0,0,1,8'hFF,1,1,0));
      step("br_lu_fl2",  24'h0, 24'h0, 0, 0, 8'h00, 0, 0, FL2,  FL2);
      step("br_lu_run",  24'h0, 24'h0, 0, 0, 8'h00, 0, 0, ZERO, ZERO);

      step("jump",       24'h0, 24'hC0005A, 0, 0, 8'h00, 0, 0,
           v(0,0,1,8'h5A,1,0,0), v(0,0,1,8'h5A,1,0,0));
      step("jump_after", 24'h0, 24'h0, 0, 0, 8'h00, 0, 0, ZERO, ZERO);
      step("br_not_tkn", 24'h0, 24'h0, 1, 0, 8'h77, 0, 0, ZERO, ZERO);
      step("br_no_valid",24'h0, 24'h0, 0, 1, 8'h77, 0, 0, ZERO, ZERO);

      // Branch beats a concurrent ID jump; FLUSH2 ignores ID but honours a branch
      step("br_vs_jmp",  24'h0, 24'hC0005A, 1, 1, 8'h20, 0, 0,
           v(0,0,1,8'h20,1,1,0), v(0,0,1,8'h20,1,1,0));
      step("fl2_br",     24'h0, 24'hC0005A, 1, 1, 8'h44, 0, 0,
           v(0,0,1,8'h44,1,1,0), v(0,0,1,8'h44,1,1,0));
      step("fl2_plain",  24'h0, 24'hC0005A, 0, 0, 8'h00, 0, 0, FL2,  FL2);
      step("fl2_exit",   24'h0, 24'h0,      0, 0, 8'h00, 0, 0, ZERO, ZERO);

      // Halt, held ten cycles with a taken branch ignored, then resume
      step("halt_enter", 24'h0, 24'hF00000, 0, 0, 8'h00, 0, 0,
           v(1,1,0,8'h00,1,0,0), v(1,1,0,8'h00,1,0,0));
      for (int i = 0; i < 10; i++)
         step($sformatf("halt_hold%0d", i), 24'h0, 24'h0, (i == 3), (i == 3), 8'h33, 0, 0, HLT, HLT);
      step("resume",     24'h0, 24'h0, 0, 0, 8'h00, 1, 0,
           v(1,1,0,8'h00,1,1,1), v(1,1,0,8'h00,1,1,1));
      step("post_resume",24'h0, 24'h0, 0, 0, 8'h00, 0, 0, ZERO, ZERO);

      // Reset asserted mid-cycle while halted masks every output
      step("halt_again", 24'h0, 24'hF00000, 0, 0, 8'h00, 0, 0,
           v(1,1,0,8'h00,1,0,0), v(1,1,0,8'h00,1,0,0));
      step("halt_cyc",   24'h0, 24'h0,      0, 0, 8'h00, 0, 0, HLT,  HLT);
      step("rst_in_halt",24'h0, 24'hC0005A, 1, 1, 8'h20, 0, 1, ZERO, ZERO);
      step("rst_release",24'h0, 24'h0,      0, 0, 8'h00, 0, 0, ZERO, ZERO);
      step("run_jump",   24'h0, 24'hC00010, 0, 0, 8'h00, 0, 0,
           v(0,0,1,8'h10,1,0,0), v(0,0,1,8'h10,1,0,0));

      repeat (3) @(negedge clk);
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
